// File: rtl/vga_mon_pkg.sv
// Shared types and constants for the VGA timing monitor.
// Default mode is SVGA 800x600@60 (1056x628 total).
package vga_mon_pkg;

    typedef enum logic [1:0] {
        SEEK    = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } mon_state_t;

    localparam int SVGA_H_TOTAL  = 1056;
    localparam int SVGA_H_SYNC_W = 128;
    localparam int SVGA_V_TOTAL  = 628;
    localparam int SVGA_V_SYNC_W = 4;

    localparam int ERR_CNT_W   = 8;
    localparam int FRAME_CNT_W = 16;
    localparam int SUM_W       = 32;

    function automatic logic [ERR_CNT_W-1:0] sat_inc(
        input logic [ERR_CNT_W-1:0] v
    );
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/vga_period_meas.sv
// Period / pulse-width meter: counts ticks between leading edges
// and flags length, width and runaway (timeout) violations.
module vga_period_meas #(
    parameter int WIDTH    = 12,
    parameter int EXPECT   = 1056,
    parameter int EXPECT_W = 128,
    parameter int TIMEOUT  = 2112
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             lead,
    input  logic             trail,
    output logic [WIDTH-1:0] meas,
    output logic             len_err,
    output logic             width_err,
    output logic             timeout
);

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] span;
    logic             run;

    // span includes a tick landing in the same cycle as the edge
    assign span      = cnt + WIDTH'(tick);
    assign len_err   = run && lead && (span != WIDTH'(EXPECT));
    assign width_err = run && trail && (span != WIDTH'(EXPECT_W));
    assign timeout   = run && !lead && (span == WIDTH'(TIMEOUT));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            run  <= 1'b0;
            meas <= '0;
        end else if (lead) begin
            cnt <= '0;
            run <= 1'b1;
            if (run) meas <= span;
        end else if (timeout) begin
            cnt  <= '0;
            run  <= 1'b0;
            meas <= WIDTH'(TIMEOUT);
        end else if (run) begin
            cnt <= span;
        end
    end

endmodule

// File: rtl/vga_timing_monitor.sv
// VGA timing checker: line/frame period and sync width checks,
// lock tracking, sticky errors, frame counter and pixel checksum.
module vga_timing_monitor
    import vga_mon_pkg::*;
#(
    parameter int H_TOTAL     = SVGA_H_TOTAL,
    parameter int V_TOTAL     = SVGA_V_TOTAL,
    parameter int H_SYNC_W    = SVGA_H_SYNC_W,
    parameter int V_SYNC_W    = SVGA_V_SYNC_W,
    parameter bit HS_POL      = 1'b1,
    parameter bit VS_POL      = 1'b1,
    parameter int COLOR_W     = 4,
    parameter int LOCK_FRAMES = 2,
    parameter int CNT_W       = 12
) (
    input  logic                   pclk,
    input  logic                   rst,
    input  logic                   hs,
    input  logic                   vs,
    input  logic [COLOR_W-1:0]     r,
    input  logic [COLOR_W-1:0]     g,
    input  logic [COLOR_W-1:0]     b,
    input  logic                   clr_err,
    output logic                   locked,
    output logic                   err_hlen,
    output logic                   err_hsw,
    output logic                   err_vlen,
    output logic                   err_vsw,
    output logic [ERR_CNT_W-1:0]   err_cnt,
    output logic [CNT_W-1:0]       h_meas,
    output logic [CNT_W-1:0]       v_meas,
    output logic [FRAME_CNT_W-1:0] frame_cnt,
    output logic                   frame_done,
    output logic [SUM_W-1:0]       frame_sum
);

    localparam int CLEAN_W = $clog2(LOCK_FRAMES + 1);

    logic                   hs_q, vs_q, hs_d, vs_d;
    logic [3*COLOR_W-1:0]   rgb_q;
    logic [1:0]             warm;
    logic                   hs_lead, hs_trail, vs_lead, vs_trail;
    logic [SUM_W-1:0]       pix, acc;

    logic                   h_len_err, h_w_err, h_tmo;
    logic                   v_len_err, v_w_err, v_tmo;
    logic                   checks_on, err_evt, tmo;
    logic                   new_hlen, new_hsw, new_vlen, new_vsw;

    mon_state_t             state, state_nxt;
    logic [CLEAN_W-1:0]     clean, clean_nxt;
    logic                   frame_bad, bad_nxt;

    // warm masks edges until hs_d/vs_d hold real samples after reset
    always_ff @(posedge pclk) begin
        if (rst) begin
            hs_q  <= ~HS_POL;
            vs_q  <= ~VS_POL;
            hs_d  <= ~HS_POL;
            vs_d  <= ~VS_POL;
            rgb_q <= '0;
            warm  <= '0;
        end else begin
            hs_q  <= hs;
            vs_q  <= vs;
            hs_d  <= hs_q;
            vs_d  <= vs_q;
            rgb_q <= {r, g, b};
            warm  <= {warm[0], 1'b1};
        end
    end

    assign hs_lead  = warm[1] && (hs_q == HS_POL) && (hs_d != HS_POL);
    assign hs_trail = warm[1] && (hs_q != HS_POL) && (hs_d == HS_POL);
    assign vs_lead  = warm[1] && (vs_q == VS_POL) && (vs_d != VS_POL);
    assign vs_trail = warm[1] && (vs_q != VS_POL) && (vs_d == VS_POL);
    assign pix      = SUM_W'(rgb_q);

    vga_period_meas #(
        .WIDTH    (CNT_W),
        .EXPECT   (H_TOTAL),
        .EXPECT_W (H_SYNC_W),
        .TIMEOUT  (2 * H_TOTAL)
    ) u_h_meas (
        .clk       (pclk),
        .rst       (rst),
        .tick      (1'b1),
        .lead      (hs_lead),
        .trail     (hs_trail),
        .meas      (h_meas),
        .len_err   (h_len_err),
        .width_err (h_w_err),
        .timeout   (h_tmo)
    );

    vga_period_meas #(
        .WIDTH    (CNT_W),
        .EXPECT   (V_TOTAL),
        .EXPECT_W (V_SYNC_W),
        .TIMEOUT  (2 * V_TOTAL)
    ) u_v_meas (
        .clk       (pclk),
        .rst       (rst),
        .tick      (hs_lead),
        .lead      (vs_lead),
        .trail     (vs_trail),
        .meas      (v_meas),
        .len_err   (v_len_err),
        .width_err (v_w_err),
        .timeout   (v_tmo)
    );

    assign checks_on = (state != SEEK);
    assign new_hlen  = checks_on && (h_len_err || h_tmo);
    assign new_hsw   = checks_on && h_w_err;
    assign new_vlen  = checks_on && (v_len_err || v_tmo);
    assign new_vsw   = checks_on && v_w_err;
    assign err_evt   = new_hlen || new_hsw || new_vlen || new_vsw;
    assign tmo       = checks_on && (h_tmo || v_tmo);
    assign locked    = (state == LOCKED);

    always_ff @(posedge pclk) begin
        if (rst) begin
            state     <= SEEK;
            clean     <= '0;
            frame_bad <= 1'b0;
        end else begin
            state     <= state_nxt;
            clean     <= clean_nxt;
            frame_bad <= bad_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        clean_nxt = clean;
        bad_nxt   = vs_lead ? 1'b0 : (frame_bad || err_evt);
        unique case (state)
            SEEK: begin
                if (vs_lead) begin
                    state_nxt = MEASURE;
                    clean_nxt = '0;
                end
            end
            MEASURE: begin
                if (tmo) begin
                    state_nxt = SEEK;
                    clean_nxt = '0;
                end else if (vs_lead) begin
                    if (frame_bad || err_evt) begin
                        clean_nxt = '0;
                    end else if (clean == CLEAN_W'(LOCK_FRAMES - 1)) begin
                        state_nxt = LOCKED;
                        clean_nxt = '0;
                    end else begin
                        clean_nxt = clean + 1'b1;
                    end
                end else if (err_evt) begin
                    clean_nxt = '0;
                end
            end
            LOCKED: begin
                if (tmo) begin
                    state_nxt = SEEK;
                    clean_nxt = '0;
                end else if (err_evt) begin
                    state_nxt = MEASURE;
                    clean_nxt = '0;
                end
            end
            default: begin
                state_nxt = SEEK;
                clean_nxt = '0;
            end
        endcase
    end

    // a new error wins over a same-cycle clear
    always_ff @(posedge pclk) begin
        if (rst) begin
            err_hlen   <= 1'b0;
            err_hsw    <= 1'b0;
            err_vlen   <= 1'b0;
            err_vsw    <= 1'b0;
            err_cnt    <= '0;
            frame_cnt  <= '0;
            frame_done <= 1'b0;
            frame_sum  <= '0;
            acc        <= '0;
        end else begin
            err_hlen   <= (err_hlen && !clr_err) || new_hlen;
            err_hsw    <= (err_hsw && !clr_err) || new_hsw;
            err_vlen   <= (err_vlen && !clr_err) || new_vlen;
            err_vsw    <= (err_vsw && !clr_err) || new_vsw;
            frame_done <= vs_lead;
            if (clr_err) begin
                err_cnt <= ERR_CNT_W'(err_evt);
            end else if (err_evt) begin
                err_cnt <= sat_inc(err_cnt);
            end
            if (vs_lead) begin
                frame_cnt <= frame_cnt + 1'b1;
                frame_sum <= acc + pix;
                acc       <= '0;
            end else begin
                acc <= acc + pix;
            end
        end
    end

endmodule
